// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences a shared-ALU/shared-memory datapath,
// stalls on mem_ready, flags illegal instructions and counts retirements.
module multicycle_controller #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op_code,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               iord,
    output logic               mem_w,
    output logic               ir_w,
    output logic               reg_dest,
    output logic               mem_to_reg,
    output logic               reg_w,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         pc_src,
    output logic               pc_en,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] retired
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BEQ, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    state_t state;
    logic   is_store;
    logic   decode_ok;

    always_comb begin
        decode_ok = 1'b0;
        unique case (op_code)
            OP_R: begin
                unique case (funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT: decode_ok = 1'b1;
                    default:                          decode_ok = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: decode_ok = 1'b1;
            default:                             decode_ok = 1'b0;
        endcase
    end

    // lw/sw choice is latched in DECODE so op_code is ignored in MEMADR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RESET;
            is_store <= 1'b0;
            retired  <= '0;
        end else begin
            unique case (state)
                S_RESET:  state <= S_FETCH;
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    is_store <= (op_code == OP_SW);
                    if (!decode_ok) state <= S_FETCH;
                    else begin
                        unique case (op_code)
                            OP_LW, OP_SW: state <= S_MEMADR;
                            OP_BEQ:       state <= S_BEQ;
                            OP_ADDI:      state <= S_ADDIEX;
                            OP_J:         state <= S_JUMP;
                            default:      state <= S_EXECUTE;
                        endcase
                    end
                end
                S_MEMADR:  state <= is_store ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (mem_ready) state <= S_MEMWB;
                S_MEMWR: begin
                    if (mem_ready) begin
                        state   <= S_FETCH;
                        retired <= retired + COUNT_W'(1);
                    end
                end
                S_EXECUTE: state <= S_ALUWB;
                S_ADDIEX:  state <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_BEQ, S_ADDIWB, S_JUMP: begin
                    state   <= S_FETCH;
                    retired <= retired + COUNT_W'(1);
                end
                default:   state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        iord        = 1'b0;
        mem_w       = 1'b0;
        ir_w        = 1'b0;
        reg_dest    = 1'b0;
        mem_to_reg  = 1'b0;
        reg_w       = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b010;
        pc_src      = 2'b00;
        pc_en       = 1'b0;
        illegal_op  = 1'b0;
        unique case (state)
            S_RESET:  alu_control = 3'b000;
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_w      = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = ~decode_ok;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD:  iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_w      = 1'b1;
            end
            S_MEMWR: begin
                iord  = 1'b1;
                mem_w = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                unique case (funct)
                    F_SUB:   alu_control = 3'b110;
                    F_AND:   alu_control = 3'b000;
                    F_OR:    alu_control = 3'b001;
                    F_SLT:   alu_control = 3'b111;
                    default: alu_control = 3'b010;
                endcase
            end
            S_ALUWB: begin
                reg_dest = 1'b1;
                reg_w    = 1'b1;
            end
            S_BEQ: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                pc_en       = zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_w = 1'b1;
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle MIPS control FSM that sequences a shared-ALU, shared-memory datapath over 3–5 cycles per instruction. It sits beside the datapath and replaces the single-cycle combinational decoder path. It drives every multiplexer select and write enable, and stalls on a memory ready handshake. It also reports illegal instructions and keeps a retired-instruction count.

## Interface
- COUNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op_code  in  6  instruction[31:26] from instruction register
- funct  in  6  instruction[5:0] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_w  out  1  memory write enable
- ir_w  out  1  instruction register load
- reg_dest  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = memory data
- reg_w  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC load = pc_w | (branch & zero)
- illegal_op  out  1  one-cycle pulse on unsupported op_code or funct
- retired  out  COUNT_W  count of completed instructions

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- R funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- All outputs are Moore-decoded from state. Exceptions: pc_en and ir_w in FETCH are qualified by mem_ready, and pc_en in BEQ is qualified by zero.
- Any output not listed for a state is 0. alu_control defaults to 010.
- RESET: entered only by rst_n, all outputs 0 → FETCH.
- FETCH: src_a=0, src_b=01, add, pc_src=00, iord=0.
  - mem_ready=1: ir_w=1, pc_en=1 → DECODE.
  - mem_ready=0: ir_w=0, pc_en=0, stay.
- DECODE: src_a=0, src_b=11, add (branch target into ALUOut).
  - lw/sw → MEMADR, R → EXECUTE, beq → BEQ, addi → ADDIEX, j → JUMP.
  - Any other op_code, or R-type with an unlisted funct: illegal_op=1 → FETCH, no register or memory write.
- MEMADR: src_a=1, src_b=10, add. lw → MEMRD, sw → MEMWR.
- MEMRD: iord=1. Wait for mem_ready → MEMWB.
- MEMWB: reg_dest=0, mem_to_reg=1, reg_w=1 → FETCH.
- MEMWR: iord=1, mem_w=1. mem_w is held until mem_ready → FETCH.
- EXECUTE: src_a=1, src_b=00, alu_control decoded from funct → ALUWB.
- ALUWB: reg_dest=1, mem_to_reg=0, reg_w=1 → FETCH.
- BEQ: src_a=1, src_b=00, sub, pc_src=01, pc_en=zero → FETCH.
- ADDIEX: src_a=1, src_b=10, add → ADDIWB.
- ADDIWB: reg_dest=0, mem_to_reg=0, reg_w=1 → FETCH.
- JUMP: pc_src=10, pc_en=1 → FETCH.
- retired increments by 1 on the clock edge leaving MEMWB, MEMWR (with mem_ready), ALUWB, BEQ, ADDIWB or JUMP.
  - Illegal instructions do not count.
  - The counter wraps modulo 2^COUNT_W.

## Timing
- Reset: state=RESET, retired=0, all outputs 0 while rst_n=0 and the cycle after release. The first FETCH is in the second cycle after deassertion.
- rst_n assertion mid-instruction clears the state immediately (async). No reg_w or mem_w may remain asserted after the asserting edge.
- Cycles per instruction with mem_ready=1: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- op_code and funct are sampled only in DECODE and EXECUTE, so changes elsewhere have no effect.
- illegal_op is high for exactly the DECODE cycle.

## Test plan
- Reset with mem_ready=1, then lw (op 100011) → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_w=1, mem_to_reg=1 only in the 5th cycle. retired=1.
- R-type sub (funct 100010) → alu_control=110 in EXECUTE, reg_dest=1 in ALUWB, 4 cycles.
- beq with zero=1 → pc_en=1, pc_src=01 in BEQ. Repeat with zero=0 → pc_en=0. Both complete in 3 cycles, retired +1 each.
- sw with mem_ready low for 3 cycles in MEMWR → mem_w held 4 cycles, then FETCH. Total 7 cycles.
- op 111111, then R-type funct 000000 → illegal_op pulses 1 cycle each, reg_w and mem_w never asserted, retired unchanged.
- rst_n low during MEMWB of lw → reg_w drops immediately, retired=0. Restart goes through RESET then FETCH.
